// File: rtl/pe_dot_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : pe_dot_seq_if
//  Purpose  : Single-port BRAM bus used by pe_dot_seq. The engine drives
//             address, write data, byte enables, enable and the BRAM clock.
//             The memory returns read data RD_LATENCY cycles after the address.
//  Ports    : BRAM_ADDR   - 32-bit word address
//             BRAM_WRDATA - write data
//             BRAM_WE     - byte enables (all-ones on write cycles)
//             BRAM_EN     - high on read-issue and write cycles
//             BRAM_CLK    - copy of the engine clock
//             BRAM_RDDATA - read data from memory
//  Modports : master (engine side), slave (memory side)
//  Revision : 1.0 - initial release
// ============================================================================
interface pe_dot_seq_if #(
    parameter int DATA_WIDTH = 32
);
    logic [31:0]             BRAM_ADDR;
    logic [DATA_WIDTH-1:0]   BRAM_WRDATA;
    logic [DATA_WIDTH/8-1:0] BRAM_WE;
    logic                    BRAM_EN;
    logic                    BRAM_CLK;
    logic [DATA_WIDTH-1:0]   BRAM_RDDATA;

    modport master (
        output BRAM_ADDR,
        output BRAM_WRDATA,
        output BRAM_WE,
        output BRAM_EN,
        output BRAM_CLK,
        input  BRAM_RDDATA
    );

    modport slave (
        input  BRAM_ADDR,
        input  BRAM_WRDATA,
        input  BRAM_WE,
        input  BRAM_EN,
        input  BRAM_CLK,
        output BRAM_RDDATA
    );
endinterface
`default_nettype wire

// File: rtl/pe_dot_seq.sv
`default_nettype none
// ============================================================================
//  Module   : pe_dot_seq
//  Purpose  : BRAM-attached fixed-point matrix-vector engine. On start it
//             reads one vector and num_rows matrix rows (stored contiguously
//             after the vector at src_base), forms one signed dot product per
//             row and writes each result, shifted right by FRAC_BITS, to
//             dst_base + row.
//  Ports    : aclk      - clock
//             areset    - synchronous active-high reset
//             start     - one-cycle request, sampled only when idle
//             src_base  - word address of the vector
//             dst_base  - word address of result 0
//             num_rows  - number of rows (0 allowed)
//             busy      - high from the cycle after start through done
//             done      - one-cycle completion pulse
//             bram      - BRAM bus (pe_dot_seq_if master)
//  Options  : PE_DOT_SAT_EN - when defined, results are clamped to the
//             DATA_WIDTH signed range; otherwise the low bits are written.
//  Revision : 1.0 - initial release
// ============================================================================
module pe_dot_seq #(
    parameter int DATA_WIDTH      = 32,
    parameter int VECTOR_SIZE     = 64,
    parameter int FRAC_BITS       = 16,
    parameter int BRAM_ADDR_WIDTH = 15,
    parameter int RD_LATENCY      = 2
) (
    input  wire logic                       aclk,
    input  wire logic                       areset,
    input  wire logic                       start,
    input  wire logic [BRAM_ADDR_WIDTH-1:0] src_base,
    input  wire logic [BRAM_ADDR_WIDTH-1:0] dst_base,
    input  wire logic [15:0]                num_rows,
    output logic                            busy,
    output logic                            done,
    pe_dot_seq_if.master                    bram
);

    localparam int c_ACC_W = 2*DATA_WIDTH + $clog2(VECTOR_SIZE);
    localparam int c_CNT_W = $clog2(VECTOR_SIZE + RD_LATENCY) + 1;
    localparam int c_IDX_W = $clog2(VECTOR_SIZE);
    localparam int c_EXT_W = c_ACC_W - 2*DATA_WIDTH;

    localparam logic [c_CNT_W-1:0]         c_PHASE_LAST = c_CNT_W'(VECTOR_SIZE + RD_LATENCY - 1);
    localparam logic [c_CNT_W-1:0]         c_V_CNT      = c_CNT_W'(VECTOR_SIZE);
    localparam logic [BRAM_ADDR_WIDTH-1:0] c_V_ADDR     = BRAM_ADDR_WIDTH'(VECTOR_SIZE);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_V = 3'd1,
        S_ROW    = 3'd2,
        S_WRITE  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // r_src tracks the base of the block currently being read (vector, then
    // each row in turn); r_dst is the next result address.
    logic [BRAM_ADDR_WIDTH-1:0] r_src;
    logic [BRAM_ADDR_WIDTH-1:0] r_dst;
    logic [15:0]                r_rows_left;
    logic [c_CNT_W-1:0]         r_cnt;
    logic [c_IDX_W-1:0]         r_idx;
    // r_vld[j] is set when a read was issued j cycles ago.
    logic [RD_LATENCY:1]        r_vld;
    logic [DATA_WIDTH-1:0]      r_vbuf [VECTOR_SIZE];
    logic signed [c_ACC_W-1:0]  r_acc;

    logic                          w_phase_rd;
    logic                          w_issue;
    logic                          w_phase_end;
    logic                          w_rd_valid;
    logic [BRAM_ADDR_WIDTH-1:0]    w_rd_addr;
    logic [2*DATA_WIDTH-1:0]       w_opa;
    logic [2*DATA_WIDTH-1:0]       w_opb;
    logic [2*DATA_WIDTH-1:0]       w_prod;
    logic signed [c_ACC_W-1:0]     w_prod_ext;
    logic signed [c_ACC_W-1:0]     w_shifted;
    logic [DATA_WIDTH-1:0]         w_result;
    logic                          w_busy;
    logic                          w_done;
    logic                          w_en;
    logic                          w_we;
    logic [BRAM_ADDR_WIDTH-1:0]    w_addr;

    // ------------------------------------------------------------------
    // Read pipeline bookkeeping
    // ------------------------------------------------------------------
    assign w_phase_rd  = (r_state == S_LOAD_V) || (r_state == S_ROW);
    assign w_issue     = w_phase_rd && (r_cnt < c_V_CNT);
    assign w_phase_end = w_phase_rd && (r_cnt == c_PHASE_LAST);
    assign w_rd_valid  = r_vld[RD_LATENCY];
    assign w_rd_addr   = r_src + BRAM_ADDR_WIDTH'(r_cnt);

    // ------------------------------------------------------------------
    // Signed full-precision product. Operands are sign-extended to the
    // product width so the low 2*DATA_WIDTH bits are the exact result.
    // ------------------------------------------------------------------
    assign w_opa      = {{DATA_WIDTH{bram.BRAM_RDDATA[DATA_WIDTH-1]}}, bram.BRAM_RDDATA};
    assign w_opb      = {{DATA_WIDTH{r_vbuf[r_idx][DATA_WIDTH-1]}}, r_vbuf[r_idx]};
    assign w_prod     = w_opa * w_opb;
    assign w_prod_ext = {{c_EXT_W{w_prod[2*DATA_WIDTH-1]}}, w_prod};

    // Arithmetic shift rounds toward minus infinity.
    assign w_shifted = r_acc >>> FRAC_BITS;

`ifdef PE_DOT_SAT_EN
    localparam logic signed [c_ACC_W-1:0] c_SAT_MAX =
        {{(c_ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [c_ACC_W-1:0] c_SAT_MIN =
        {{(c_ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    always_comb begin
        w_result = w_shifted[DATA_WIDTH-1:0];
        if (w_shifted > c_SAT_MAX) begin
            w_result = c_SAT_MAX[DATA_WIDTH-1:0];
        end else if (w_shifted < c_SAT_MIN) begin
            w_result = c_SAT_MIN[DATA_WIDTH-1:0];
        end
    end
`else
    assign w_result = w_shifted[DATA_WIDTH-1:0];
`endif

    // ------------------------------------------------------------------
    // FSM state register and control registers
    // ------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state     <= S_IDLE;
            r_src       <= '0;
            r_dst       <= '0;
            r_rows_left <= '0;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_vld       <= '0;
        end else begin
            r_state <= w_state_next;

            r_vld[1] <= w_issue;
            for (int j = 2; j <= RD_LATENCY; j++) begin
                r_vld[j] <= r_vld[j-1];
            end

            if (w_phase_end) begin
                r_cnt <= '0;
            end else if (w_phase_rd) begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end

            if (w_phase_end) begin
                r_idx <= '0;
            end else if (w_rd_valid) begin
                r_idx <= r_idx + c_IDX_W'(1);
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_src       <= src_base;
                        r_dst       <= dst_base;
                        r_rows_left <= num_rows;
                    end
                end
                S_LOAD_V, S_ROW: begin
                    // Advance to the next contiguous block of V words.
                    if (w_phase_end) begin
                        r_src <= r_src + c_V_ADDR;
                    end
                end
                S_WRITE: begin
                    r_dst       <= r_dst + BRAM_ADDR_WIDTH'(1);
                    r_rows_left <= r_rows_left - 16'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // Vector buffer and accumulator carry no reset; their contents are
    // always rewritten before use.
    always_ff @(posedge aclk) begin
        if ((r_state == S_LOAD_V) && w_rd_valid) begin
            r_vbuf[r_idx] <= bram.BRAM_RDDATA;
        end
        if (((r_state == S_LOAD_V) && w_phase_end) || (r_state == S_WRITE)) begin
            r_acc <= '0;
        end else if ((r_state == S_ROW) && w_rd_valid) begin
            r_acc <= r_acc + w_prod_ext;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        w_en         = 1'b0;
        w_we         = 1'b0;
        w_addr       = '0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = (num_rows == 16'd0) ? S_DONE : S_LOAD_V;
                end
            end
            S_LOAD_V: begin
                w_busy = 1'b1;
                if (w_phase_end) begin
                    w_state_next = S_ROW;
                end
            end
            S_ROW: begin
                w_busy = 1'b1;
                if (w_phase_end) begin
                    w_state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                w_busy       = 1'b1;
                w_en         = 1'b1;
                w_we         = 1'b1;
                w_addr       = r_dst;
                w_state_next = (r_rows_left == 16'd1) ? S_DONE : S_ROW;
            end
            S_DONE: begin
                w_busy       = 1'b1;
                w_done       = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        if (w_issue) begin
            w_en   = 1'b1;
            w_addr = w_rd_addr;
        end
    end

    assign busy             = w_busy;
    assign done             = w_done;
    assign bram.BRAM_CLK    = aclk;
    assign bram.BRAM_EN     = w_en;
    assign bram.BRAM_WE     = w_we ? '1 : '0;
    assign bram.BRAM_ADDR   = 32'(w_addr);
    assign bram.BRAM_WRDATA = w_we ? w_result : '0;

endmodule
`default_nettype wire
